wm_embed_ctrl: RTL and testbench
================================

WM_EMBED_CTRL -- requirements
Module: wm_embed_ctrl

Interface
REQ-001 Parameter NUM_PIX, default 16, meaning number of pixels embedded per frame (legal 1..65535).
REQ-002 Parameter CNT_W, default 16, meaning width of the pixel counter and pix_count.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  frame start request; sampled only in IDLE.
REQ-006 key  input  8  LFSR seed, captured with start.
REQ-007 wm_select  input  1  embedding mode, captured with start: 0 = 1 LSB, 1 = 2 LSBs.
REQ-008 pix_in, pix_in_valid / pix_in_ready  input 8, input 1 / output 1  input pixel stream; transfer when valid and ready are both high.
REQ-009 pix_out, pix_out_valid / pix_out_ready  output 8, output 1 / input 1  watermarked pixel stream; same transfer rule.
REQ-010 busy  output  1  high in LOAD, RUN, DRAIN.
REQ-011 done  output  1  one-cycle pulse at frame completion.
REQ-012 pix_count  output  CNT_W  pixels accepted in the current frame.

Function
REQ-013 States: IDLE, LOAD, RUN, DRAIN, DONE.
REQ-014 IDLE -> LOAD on start=1; start is ignored in all other states.
REQ-015 LOAD lasts one cycle; key and wm_select are latched at the IDLE->LOAD edge; the LFSR is loaded with key, or 8'h01 if key=8'h00 (lock-up avoidance); pix_count is cleared.
REQ-016 LOAD -> RUN unconditionally.
REQ-017 LFSR: 8-bit Fibonacci; next = {q[6:0], q[7]^q[5]^q[4]^q[3]}; advances exactly once per accepted input pixel and at no other time.
REQ-018 Watermark bits from current q (before advance): wm0 = q[0]; wm1 = latched wm_select ? q[1]^q[0] : 0.
REQ-019 Embedding: mode 0 gives pix_out = {pix_in[7:1], wm0}; mode 1 gives pix_out = {pix_in[7:2], wm1, wm0}.
REQ-020 One output register stage; latency 1 cycle from input acceptance to pix_out_valid.
REQ-021 pix_in_ready = (state==RUN) && (pix_count<NUM_PIX) && (!pix_out_valid || pix_out_ready); accept and output of the prior pixel in the same cycle is legal (full throughput).
REQ-022 pix_out_valid and pix_out hold stable while pix_out_valid=1 and pix_out_ready=0.
REQ-023 pix_count increments per accepted pixel and saturates at NUM_PIX; RUN -> DRAIN in the cycle after the NUM_PIX-th acceptance.
REQ-024 DRAIN -> DONE when the output register is empty or emptying in that cycle.
REQ-025 DONE lasts one cycle with done=1, then -> IDLE; pix_count holds its final value until the next LOAD.
REQ-026 pix_in_valid outside RUN is ignored (ready=0); no pixel is dropped or duplicated under any valid/ready pattern.

Reset
REQ-027 rst_n=0 asynchronously forces state=IDLE, LFSR=8'h01, pix_out=0, pix_out_valid=0, pix_count=0, done=0, busy=0, latched wm_select=0; a mid-frame reset abandons the frame with no done pulse.
REQ-028 Release of reset is synchronised to clk; the first start is accepted in the cycle after deassertion.

Structure
REQ-029 A shared package holds the state enumeration, the LFSR tap constant, and the lock-up replacement seed 8'h01.
REQ-030 The LFSR is a sub-module wm_lfsr (ports clk, rst_n, load, seed, step, q), reused by the later extraction block.

Verification
REQ-031 key=8'h01, wm_select=0, NUM_PIX=5, pix_in=8'hFF, ready always 1 -> pix_out FF,FE,FE,FE,FF; done pulses once; pix_count=5.
REQ-032 The same with wm_select=1 -> pix_out FF,FE,FC,FC,FF.
REQ-033 key=8'h00 -> output identical to REQ-031 (seed forced to 8'h01).
REQ-034 Random pix_out_ready and pix_in_valid stalls -> output sequence identical to the unstalled run; pix_out is stable while stalled.
REQ-035 rst_n pulsed low after the 3rd pixel -> immediate IDLE, outputs zero, no done; a fresh start reproduces the REQ-031 sequence from its first pixel.
REQ-036 start asserted during RUN -> ignored; the frame completes normally with exactly NUM_PIX outputs.

Source files
------------

// File: rtl/wm_embed_ctrl_pkg.sv
// Shared definitions for the watermark embed/extract blocks: controller states
// and the 8-bit Fibonacci LFSR constants.
package wm_embed_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  // Feedback taps q[7]^q[5]^q[4]^q[3]
  localparam logic [7:0] LFSR_TAPS      = 8'hB8;
  localparam logic [7:0] LFSR_SAFE_SEED = 8'h01;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced.
  function automatic logic [7:0] lfsr_seed_fix(input logic [7:0] seed);
    return (seed == 8'h00) ? LFSR_SAFE_SEED : seed;
  endfunction

endpackage

// File: rtl/wm_lfsr.sv
// 8-bit Fibonacci LFSR with synchronous seed load and single-step advance;
// shared between the embed and extract controllers.
module wm_lfsr
  import wm_embed_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = lfsr_seed_fix(seed);
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= LFSR_SAFE_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/wm_embed_ctrl.sv
// Frame controller that replaces the low one or two bits of each pixel with
// LFSR-derived watermark bits, behind a single registered output stage.
module wm_embed_ctrl
  import wm_embed_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PIX = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       key,
  input  logic             wm_select,
  input  logic [7:0]       pix_in,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  output logic [7:0]       pix_out,
  output logic             pix_out_valid,
  input  logic             pix_out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pix_count
);

  localparam logic [CNT_W-1:0] NUM_C = CNT_W'(NUM_PIX);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       out_q, out_d;
  logic             ov_q, ov_d;

  logic [7:0] lfsr_q;
  logic       lfsr_load;
  logic       accept;
  logic       count_full;
  logic       wm0, wm1;
  logic [7:0] embedded;

  // The LFSR takes the key on the IDLE->LOAD edge itself, so it already holds
  // the seed during LOAD and no separate key register is needed.
  assign lfsr_load = (state_q == S_IDLE) && start;

  assign count_full   = (cnt_q == NUM_C);
  assign pix_in_ready = (state_q == S_RUN) && !count_full && (!ov_q || pix_out_ready);
  assign accept       = pix_in_valid && pix_in_ready;

  wm_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (key),
    .step  (accept),
    .q     (lfsr_q)
  );

  assign wm0      = lfsr_q[0];
  assign wm1      = mode_q & (lfsr_q[1] ^ lfsr_q[0]);
  assign embedded = mode_q ? {pix_in[7:2], wm1, wm0} : {pix_in[7:1], wm0};

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ov_d    = ov_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          mode_d  = wm_select;
          cnt_d   = '0;
        end
      end
      S_LOAD:  state_d = S_RUN;
      S_RUN: begin
        if (count_full) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!ov_q || pix_out_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      out_d = embedded;
      ov_d  = 1'b1;
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pix_out_ready) begin
      ov_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  assign pix_out       = out_q;
  assign pix_out_valid = ov_q;
  assign pix_count     = cnt_q;
  assign busy          = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_wm_embed_ctrl.sv
// Self-checking bench for wm_embed_ctrl: known-answer frames, randomized
// stall patterns against a behavioural model, mid-frame reset, ignored start.
module tb_wm_embed_ctrl;

  localparam int NPIX = 5;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  key;
  logic        wm_select;
  logic [7:0]  pix_in;
  logic        pix_in_valid;
  logic        pix_in_ready;
  logic [7:0]  pix_out;
  logic        pix_out_valid;
  logic        pix_out_ready;
  logic        busy;
  logic        done;
  logic [15:0] pix_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] px_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] ref_q[$];
  int         done_cnt;
  int         stall_err;
  bit         prev_stall;
  logic [7:0] prev_val;
  logic [7:0] tab0[NPIX];
  logic [7:0] tab1[NPIX];

  wm_embed_ctrl #(.NUM_PIX(NPIX), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .key           (key),
    .wm_select     (wm_select),
    .pix_in        (pix_in),
    .pix_in_valid  (pix_in_valid),
    .pix_in_ready  (pix_in_ready),
    .pix_out       (pix_out),
    .pix_out_valid (pix_out_valid),
    .pix_out_ready (pix_out_ready),
    .busy          (busy),
    .done          (done),
    .pix_count     (pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change at posedge+1, so negedge values equal those seen by the DUT.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!pix_out_valid || pix_out !== prev_val)) stall_err++;
      if (pix_out_valid && pix_out_ready) got_q.push_back(pix_out);
      prev_stall = pix_out_valid && !pix_out_ready;
      prev_val   = pix_out;
      if (done) done_cnt++;
    end
  end

  // Reference: seed, step the Fibonacci sequence once per pixel, splice bits.
  function automatic void build_exp(input logic [7:0] k, input logic m,
                                    input logic [7:0] px[$], output logic [7:0] ex[$]);
    logic [7:0] s;
    logic       w0, w1;
    ex.delete();
    s = (k == 8'h00) ? 8'h01 : k;
    foreach (px[i]) begin
      w0 = s[0];
      w1 = m ? (s[1] ^ s[0]) : 1'b0;
      if (m) ex.push_back((px[i] & 8'hFC) | {6'b0, w1, w0});
      else   ex.push_back((px[i] & 8'hFE) | {7'b0, w0});
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
  endfunction

  task automatic run_frame(input logic [7:0] k, input logic m, input bit stall, input bit start_in_run);
    int idx;
    int cyc;
    bit acc;
    got_q.delete();
    done_cnt  = 0;
    stall_err = 0;
    @(posedge clk); #1;
    key = k; wm_select = m; start = 1'b1;
    @(posedge clk); #1;
    start = start_in_run; key = 8'($urandom); wm_select = 1'($urandom);
    idx = 0; cyc = 0;
    while ((done_cnt == 0) && (cyc < 2000)) begin
      if (idx >= px_q.size()) start = 1'b0;
      pix_in_valid  = (idx < px_q.size()) && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
      pix_in        = (idx < px_q.size()) ? px_q[idx] : 8'($urandom);
      pix_out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      acc = pix_in_valid && pix_in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    start = 1'b0; pix_in_valid = 1'b0; pix_out_ready = 1'b1;
    checks++;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL frame_timeout: done not seen after %0d cycles, required within 2000", cyc);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; key = '0; wm_select = 1'b0;
    pix_in = '0; pix_in_valid = 1'b0; pix_out_ready = 1'b0;
    #23;
    checks++; if (pix_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pix_out_valid); end
    checks++; if (pix_out !== 8'h00) begin errors++; $display("FAIL reset_pix_out: got %h want 00", pix_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (pix_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", pix_count); end
    checks++; if (pix_in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", pix_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_known(input string name, input logic [7:0] k, input logic m, input logic [7:0] t[NPIX]);
    px_q.delete();
    for (int i = 0; i < NPIX; i++) px_q.push_back(8'hFF);
    run_frame(k, m, 1'b0, 1'b0);
    build_exp(k, m, px_q, exp_q);
    checks++;
    if (got_q.size() != NPIX) begin
      errors++; $display("FAIL %s_len: got %0d outputs want %0d", name, got_q.size(), NPIX);
    end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== t[i] || exp_q[i] !== t[i]) begin
        errors++;
        $display("FAIL %s_pix%0d: got %h want %h (model %h)", name, i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, t[i], exp_q[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done: got %0d pulses want 1", name, done_cnt); end
    checks++; if (pix_count !== 16'(NPIX)) begin errors++; $display("FAIL %s_count: got %0d want %0d", name, pix_count, NPIX); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b want 0", name, busy); end
  endtask

  task automatic test_stall_random();
    logic [7:0] k;
    logic       m;
    for (int f = 0; f < 4; f++) begin
      k = 8'($urandom); m = 1'($urandom);
      if (f == 0) k = 8'h00;
      px_q.delete();
      for (int i = 0; i < NPIX; i++) px_q.push_back(8'($urandom));
      build_exp(k, m, px_q, exp_q);
      run_frame(k, m, 1'b0, 1'b0);
      ref_q = got_q;
      run_frame(k, m, 1'b1, 1'b0);
      checks++;
      if (got_q.size() != NPIX || ref_q.size() != NPIX) begin
        errors++; $display("FAIL stall_len%0d: got %0d/%0d outputs want %0d", f, ref_q.size(), got_q.size(), NPIX);
      end
      for (int i = 0; i < NPIX; i++) begin
        checks++;
        if (i >= got_q.size() || i >= ref_q.size() || got_q[i] !== exp_q[i] || ref_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL stall_pix%0d_%0d: stalled %h unstalled %h want %h", f, i,
                   (i < got_q.size()) ? got_q[i] : 8'hxx, (i < ref_q.size()) ? ref_q[i] : 8'hxx, exp_q[i]);
        end
      end
      checks++; if (stall_err != 0) begin errors++; $display("FAIL stall_hold%0d: %0d unstable cycles want 0", f, stall_err); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done%0d: got %0d pulses want 1", f, done_cnt); end
    end
  endtask

  task automatic test_mid_reset();
    int acc_n;
    int cyc;
    done_cnt = 0;
    @(posedge clk); #1;
    key = 8'h01; wm_select = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; pix_in = 8'hFF; pix_in_valid = 1'b1; pix_out_ready = 1'b1;
    acc_n = 0; cyc = 0;
    while (acc_n < 3 && cyc < 100) begin
      @(negedge clk);
      if (pix_in_valid && pix_in_ready) acc_n++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (acc_n != 3) begin errors++; $display("FAIL midrst_feed: accepted %0d want 3", acc_n); end
    rst_n = 1'b0;
    #1;
    checks++; if (pix_out_valid !== 1'b0 || pix_out !== 8'h00) begin errors++; $display("FAIL midrst_out: got valid %b pix %h want 0 00", pix_out_valid, pix_out); end
    checks++; if (busy !== 1'b0 || pix_count !== 16'd0) begin errors++; $display("FAIL midrst_state: got busy %b count %0d want 0 0", busy, pix_count); end
    checks++; if (pix_in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", pix_in_ready); end
    pix_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done_cnt != 0 || done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %0d pulses want 0", done_cnt); end
    test_known("after_reset", 8'h01, 1'b0, tab0);
  endtask

  task automatic test_start_in_run();
    logic [7:0] k;
    logic       m;
    k = 8'($urandom); m = 1'($urandom);
    px_q.delete();
    for (int i = 0; i < NPIX; i++) px_q.push_back(8'($urandom));
    build_exp(k, m, px_q, exp_q);
    run_frame(k, m, 1'b0, 1'b1);
    checks++; if (got_q.size() != NPIX) begin errors++; $display("FAIL startrun_len: got %0d want %0d", got_q.size(), NPIX); end
    for (int i = 0; i < NPIX && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL startrun_pix%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL startrun_done: got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL startrun_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] k;
    logic       m;
    for (int f = 0; f < 2; f++) begin
      k = 8'($urandom); m = 1'($urandom);
      px_q.delete();
      for (int i = 0; i < NPIX; i++) px_q.push_back(8'($urandom));
      build_exp(k, m, px_q, exp_q);
      run_frame(k, m, 1'b1, 1'b0);
      checks++;
      if (got_q != exp_q) begin
        errors++; $display("FAIL b2b%0d_seq: got %p want %p", f, got_q, exp_q);
      end
      checks++; if (pix_count !== 16'(NPIX)) begin errors++; $display("FAIL b2b%0d_count: got %0d want %0d", f, pix_count, NPIX); end
    end
  endtask

  initial begin
    tab0 = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF};
    tab1 = '{8'hFF, 8'hFE, 8'hFC, 8'hFC, 8'hFF};
    test_reset();
    test_known("mode0", 8'h01, 1'b0, tab0);
    test_known("mode1", 8'h01, 1'b1, tab1);
    test_known("key0", 8'h00, 1'b0, tab0);
    test_stall_random();
    test_mid_reset();
    test_start_in_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
